// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver/transmitter FSM state
//               encoding and frame timing constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Receiver/transmitter frame states (explicit 3-bit encoding)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  localparam int OVERSAMPLE = 16;  // ticks per bit
  localparam int MID_SAMPLE = 7;   // tick index of start-bit mid sample
  localparam int DATA_BITS  = 8;   // payload bits per frame

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_sync_fifo.sv
// ============================================================================
// Module      : uart_rx_sync_fifo
// Description : Single-clock FIFO with registered storage. A push into a full
//               FIFO is accepted only when a pop happens in the same cycle.
//               Pop on empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             pop_ok;
  logic             push_ok;

  assign full_o  = (count_q == C_DEPTH);
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // When full, the write slot is the head being popped this cycle
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage write; cleared on reset so the head reads 0 when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Read/write pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : uart_rx_sync_fifo

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : 16x oversampling UART receiver with byte FIFO and
//               valid/ready output. Flags framing and overrun errors.
//               Build option UART_RX_PARITY_EN: 8E1 framing with a PARITY
//               state and a parity_err pulse output; otherwise 8N1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int              PW        = $clog2(BAUD_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(BAUD_DIV - 1);
  localparam logic [3:0]      TICK_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0]      TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

  logic                   sync1_q;
  logic                   sync2_q;
  logic                   rx_s;
  logic [PW-1:0]          presc_q;
  logic                   tick;
  logic [3:0]             tick_cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   samp_mid;
  logic                   samp_bit;
  uart_state_e            state_q;
  uart_state_e            state_d;
  logic                   data_samp;
  logic                   push;
  logic                   pop;
  logic                   frame_err_d;
  logic                   frame_err_q;
  logic                   overrun_d;
  logic                   overrun_q;
  logic                   fifo_full;
  logic                   fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                   par_samp;
  logic                   par_bad_q;
  logic                   parity_err_d;
  logic                   parity_err_q;
`endif

  // Two-flop synchronizer, preset to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Prescaler: held at 0 in IDLE so every frame starts on a fresh tick phase
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign tick     = (state_q != IDLE) && (presc_q == PRESC_MAX);
  assign samp_mid = tick && (tick_cnt_q == TICK_MID);
  assign samp_bit = tick && (tick_cnt_q == TICK_LAST);

  // Tick counter: restarts on every state change, wraps every 16 ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (state_d != state_q) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= tick_cnt_q + 4'd1;
    end
  end

  // Bit counter: counts sampled data bits, idle outside DATA
  always_ff @(posedge clk) begin
    if (rst || state_q != DATA) begin
      bit_cnt_q <= '0;
    end else if (data_samp) begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  // Shift register: LSB arrives first, so shift in from the top
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
    end else if (data_samp) begin
      shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict held until the stop bit decides whether to push
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) begin
      par_bad_q <= 1'b0;
    end else if (par_samp) begin
      par_bad_q <= (rx_s != ^shift_q);
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rx_s) state_d = START;
      START:  if (samp_mid) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (samp_bit && bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (samp_bit) state_d = STOP;
`endif
      STOP:   if (samp_bit) state_d = rx_s ? IDLE : BREAK;
      BREAK:  if (tick && rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: sample strobes, push and error conditions
  always_comb begin
    data_samp   = 1'b0;
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_samp     = 1'b0;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      DATA: data_samp = samp_bit;
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        par_samp     = samp_bit;
        parity_err_d = samp_bit && (rx_s != ^shift_q);
      end
      STOP: begin
        push        = samp_bit && rx_s && !par_bad_q;
        frame_err_d = samp_bit && !rx_s;
      end
`else
      STOP: begin
        push        = samp_bit && rx_s;
        frame_err_d = samp_bit && !rx_s;
      end
`endif
      default: ;
    endcase
  end

  assign pop       = rx_valid && rx_ready;
  assign overrun_d = push && fifo_full && !pop;

  // Error pulses registered for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`endif

  uart_rx_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rx_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule : uart_rx_fifo

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo with a byte scoreboard.
//               Honours UART_RX_PARITY_EN (adds 8E1 parity bit and test).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int BAUD_DIV   = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_CLKS   = BAUD_DIV * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Clock edges from driving the start bit to the stop-bit sample edge:
  // 2 sync + 1 detect, half a bit to the start mid sample, then one bit each
  localparam int STOP_EDGE = 3 + (MID_SAMPLE + 1) * BAUD_DIV
                           + BIT_CLKS * (DATA_BITS + PAR_BITS + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [3:0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  bit         flip_par = 1'b0;
  int         pe_cnt   = 0;
`endif

  int         n_cmp   = 0;
  int         n_err   = 0;
  int         pop_cnt = 0;
  int         fe_cnt  = 0;
  int         ov_cnt  = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .BAUD_DIV   (BAUD_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare each byte the consumer takes
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) chk("unexpected_pop", 32'(exp_q.size()), 32'd1);
        else                   chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
    end
  end

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_bits(input int n);
    repeat (n * BIT_CLKS) @(posedge clk);
    #1;
  endtask

  // Drive one frame starting now; stop_low > 0 holds the line low that many bit times
  task automatic send_frame(input logic [7:0] d, input int stop_low);
    rx = 1'b0;
    hold_bits(1);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = d[i];
      hold_bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ flip_par;
    hold_bits(1);
`endif
    if (stop_low > 0) begin
      rx = 1'b0;
      hold_bits(stop_low);
    end
    rx = 1'b1;
    hold_bits(1);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit expect_it);
    sync_edge();
    if (expect_it) exp_q.push_back(d);
    send_frame(d, 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    rx_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("count_after_drain", 32'(fifo_count), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, o0;
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);

    // Two back-to-back bytes with a ready consumer
    p0 = pop_cnt;
    send_byte(8'h55, 1'b1);
    send_byte(8'hA3, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("two_bytes_pops", 32'(pop_cnt - p0), 32'd2);
    chk("two_bytes_sb", 32'(exp_q.size()), 32'd0);
    chk("two_bytes_fe", 32'(fe_cnt), 32'd0);
    chk("two_bytes_ov", 32'(ov_cnt), 32'd0);

    // Short low glitch on an idle line is rejected
    p0 = pop_cnt;
    sync_edge();
    rx = 1'b0;
    repeat (3 * BAUD_DIV) @(posedge clk);
    #1 rx = 1'b1;
    hold_bits(2);
    @(negedge clk);
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    chk("glitch_pops", 32'(pop_cnt - p0), 32'd0);
    chk("glitch_fe", 32'(fe_cnt), 32'd0);

    // Stop bit held low for two bit times: one framing error, byte dropped
    p0 = pop_cnt;
    f0 = fe_cnt;
    sync_edge();
    send_frame(8'h3C, 2);
    @(negedge clk);
    chk("break_fe", 32'(fe_cnt - f0), 32'd1);
    chk("break_count", 32'(fifo_count), 32'd0);
    chk("break_pops", 32'(pop_cnt - p0), 32'd0);
    send_byte(8'h81, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("after_break_pops", 32'(pop_cnt - p0), 32'd1);
    chk("after_break_fe", 32'(fe_cnt - f0), 32'd1);

    // Overfill with consumer stalled: one overrun, first eight bytes kept
    o0 = ov_cnt;
    rx_ready = 1'b0;
    for (int b = 0; b <= FIFO_DEPTH; b++) begin
      send_byte(8'(b), b < FIFO_DEPTH);
    end
    @(negedge clk);
    chk("full_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    chk("full_overrun", 32'(ov_cnt - o0), 32'd1);
    chk("full_head_hold", 32'(rx_data), 32'h00);
    drain(200);

    // Full FIFO with a pop in the stop-sample cycle: push accepted, no overrun
    rx_ready = 1'b0;
    for (int b = 0; b < FIFO_DEPTH; b++) begin
      send_byte(8'(8'h10 + b), 1'b1);
    end
    @(negedge clk);
    chk("refill_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    o0 = ov_cnt;
    p0 = pop_cnt;
    sync_edge();
    exp_q.push_back(8'h77);
    fork
      send_frame(8'h77, 0);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    @(negedge clk);
    chk("pop_push_overrun", 32'(ov_cnt - o0), 32'd0);
    chk("pop_push_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    chk("pop_push_pops", 32'(pop_cnt - p0), 32'd1);
    drain(200);

    // Reset mid-frame discards partial byte and FIFO contents
    rx_ready = 1'b0;
    send_byte(8'h42, 1'b1);
    @(negedge clk);
    chk("pre_rst_count", 32'(fifo_count), 32'd1);
    sync_edge();
    fork
      send_frame(8'hF8, 0);
      begin
        repeat (5 * BIT_CLKS + 20) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 32'(rx_valid), 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_fe", 32'(frame_err), 32'd0);
        chk("midrst_ov", 32'(overrun), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    rx_ready = 1'b1;
    p0 = pop_cnt;
    f0 = fe_cnt;
    send_byte(8'hF0, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_pops", 32'(pop_cnt - p0), 32'd1);
    chk("post_rst_fe", 32'(fe_cnt - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Wrong parity: parity error pulse, byte dropped, no framing error
    begin
      int e0;
      e0 = pe_cnt;
      p0 = pop_cnt;
      f0 = fe_cnt;
      flip_par = 1'b1;
      send_byte(8'h01, 1'b0);
      flip_par = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("parity_err_pulse", 32'(pe_cnt - e0), 32'd1);
      chk("parity_pops", 32'(pop_cnt - p0), 32'd0);
      chk("parity_fe", 32'(fe_cnt - f0), 32'd0);
      chk("parity_count", 32'(fifo_count), 32'd0);
    end
`endif

    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_rx_fifo

`default_nettype wire
